// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DIV_ITERS = 32;
  localparam int CNT_W     = 5;
  localparam int WORD_W    = 32;

  typedef logic [WORD_W-1:0] word_t;

  // Two's-complement negate when neg is set; -0x80000000 wraps to itself,
  // which is also the correct unsigned magnitude of the most negative value.
  function automatic word_t cond_neg(input word_t v, input logic neg);
    return neg ? word_t'(-v) : v;
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Operand/result handshake between the control FSM and the divider.
interface seq_divider_if #(
  parameter int DIV_W = 32
);
  logic             start;
  logic             is_signed;
  logic [DIV_W-1:0] a;
  logic [DIV_W-1:0] b;
  logic [DIV_W-1:0] lo;
  logic [DIV_W-1:0] hi;
  logic             done;
  logic             div_zero;
  logic             busy;

  modport master (
    output start, is_signed, a, b,
    input  lo, hi, done, div_zero, busy
  );

  modport slave (
    input  start, is_signed, a, b,
    output lo, hi, done, div_zero, busy
  );
endinterface

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: shift {rem, dividend} left, trial-subtract divisor.
module seq_divider_div_step #(
  parameter int DIV_W = 32
) (
  input  logic [DIV_W:0]   rem,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic [DIV_W:0]   rem_next,
  output logic [DIV_W-1:0] dividend_next,
  output logic             q_bit
);

  logic [DIV_W+1:0] shifted;
  logic [DIV_W+1:0] trial;

  // rem is always below divisor, so one extra bit absorbs the shift and the borrow.
  always_comb begin
    shifted       = {rem, dividend[DIV_W-1]};
    trial         = shifted - {2'b00, divisor};
    q_bit         = ~trial[DIV_W+1];
    rem_next      = q_bit ? trial[DIV_W:0] : shifted[DIV_W:0];
    dividend_next = {dividend[DIV_W-2:0], q_bit};
  end

endmodule

// File: rtl/seq_divider.sv
// 32-cycle restoring divider for DIV/DIVU; quotient to LO, remainder to HI.
// Signed DIV support is built only when SEQ_DIVIDER_SIGNED_EN is defined.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int DIV_W = 32
) (
  input  logic          clock,
  input  logic          reset,
  seq_divider_if.slave  bus
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [DIV_W:0]   rem;
  logic [DIV_W-1:0] dvd;
  logic [DIV_W-1:0] dvs;
  logic [DIV_W-1:0] lo_q;
  logic [DIV_W-1:0] hi_q;
  logic             dz_q;

  logic [DIV_W:0]   rem_nxt;
  logic [DIV_W-1:0] dvd_nxt;
  logic             q_bit;
  logic             accept;
  logic             b_zero;
  logic [DIV_W-1:0] a_mag;
  logic [DIV_W-1:0] b_mag;
  logic [DIV_W-1:0] lo_fix;
  logic [DIV_W-1:0] hi_fix;

  assign accept = bus.start && (state == IDLE || state == DONE);
  assign b_zero = (bus.b == '0);

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic q_neg;
  logic r_neg;

  assign a_mag  = cond_neg(bus.a, bus.is_signed && bus.a[DIV_W-1]);
  assign b_mag  = cond_neg(bus.b, bus.is_signed && bus.b[DIV_W-1]);
  assign lo_fix = cond_neg(dvd, q_neg);
  assign hi_fix = cond_neg(rem[DIV_W-1:0], r_neg);

  always_ff @(posedge clock) begin
    if (!reset) begin
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else if (accept && !b_zero) begin
      q_neg <= bus.is_signed && (bus.a[DIV_W-1] ^ bus.b[DIV_W-1]);
      r_neg <= bus.is_signed && bus.a[DIV_W-1];
    end
  end
`else
  assign a_mag  = bus.a;
  assign b_mag  = bus.b;
  assign lo_fix = dvd;
  assign hi_fix = rem[DIV_W-1:0];
`endif

  seq_divider_div_step #(.DIV_W(DIV_W)) u_step (
    .rem           (rem),
    .dividend      (dvd),
    .divisor       (dvs),
    .rem_next      (rem_nxt),
    .dividend_next (dvd_nxt),
    .q_bit         (q_bit)
  );

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = b_zero ? DONE : RUN;
      RUN:     if (cnt == '0) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = accept ? (b_zero ? DONE : RUN) : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: quotient bits accumulate in dvd as the dividend shifts out.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt  <= '0;
      rem  <= '0;
      dvd  <= '0;
      dvs  <= '0;
      lo_q <= '0;
      hi_q <= '0;
      dz_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            if (b_zero) begin
              dz_q <= 1'b1;
            end else begin
              dvd  <= a_mag;
              dvs  <= b_mag;
              rem  <= '0;
              cnt  <= CNT_W'(DIV_ITERS - 1);
              dz_q <= 1'b0;
            end
          end
        end
        RUN: begin
          rem <= rem_nxt;
          dvd <= dvd_nxt;
          cnt <= cnt - 1'b1;
        end
        FIX: begin
          lo_q <= lo_fix;
          hi_q <= hi_fix;
        end
        default: ;
      endcase
    end
  end

  assign bus.lo       = lo_q;
  assign bus.hi       = hi_q;
  assign bus.div_zero = dz_q;
  assign bus.done     = (state == DONE);
  assign bus.busy     = (state == RUN) || (state == FIX);

  logic unused_q_bit;
  assign unused_q_bit = q_bit;

endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector bench for seq_divider: results, latency, div-by-zero, restart and reset.
module tb_seq_divider;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  seq_divider_if bus ();

  seq_divider dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [31:0] av, input logic [31:0] bv, input logic s);
    bus.a         = av;
    bus.b         = bv;
    bus.is_signed = s;
    bus.start     = 1'b1;
    @(posedge clock);
    #1 bus.start  = 1'b0;
  endtask

  // Counts cycles after the accepting edge until done, sampling on falling edges.
  task automatic wait_done(output int lat, output logic busy_ok);
    lat     = 0;
    busy_ok = 1'b1;
    do begin
      @(negedge clock);
      lat++;
      if (!bus.done && !bus.busy) busy_ok = 1'b0;
    end while (!bus.done && lat < 100);
    if (!bus.done) lat = -1;
  endtask

  initial begin
    int   lat;
    logic bok;

    vecs[0] = '{32'd100,      32'd7,        1'b0, 32'd14,       32'd2,        1'b0, 34};
    vecs[1] = '{32'd55,       32'd0,        1'b0, 32'd14,       32'd2,        1'b1, 1};
`ifdef SEQ_DIVIDER_SIGNED_EN
    vecs[2] = '{32'hFFFFFFF9, 32'd2,        1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 34};
    vecs[3] = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'h0,        1'b0, 34};
    vecs[5] = '{32'd7,        32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1,        1'b0, 34};
`else
    vecs[2] = '{32'hFFFFFFF9, 32'd2,        1'b1, 32'h7FFFFFFC, 32'd1,        1'b0, 34};
    vecs[3] = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h0,        32'h80000000, 1'b0, 34};
    vecs[5] = '{32'd7,        32'hFFFFFFFE, 1'b1, 32'h0,        32'd7,        1'b0, 34};
`endif
    vecs[4] = '{32'hFFFFFFFF, 32'd2,        1'b0, 32'h7FFFFFFF, 32'd1,        1'b0, 34};
    vecs[6] = '{32'd5,        32'd10,       1'b0, 32'd0,        32'd5,        1'b0, 34};
    vecs[7] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd1,        32'd0,        1'b0, 34};
    vecs[8] = '{32'h12345678, 32'd1,        1'b0, 32'h12345678, 32'd0,        1'b0, 34};

    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.a         = '0;
    bus.b         = '0;

    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_lo",   bus.lo,   32'd0);
    chk("rst_hi",   bus.hi,   32'd0);
    chk("rst_done", 32'(bus.done),     32'd0);
    chk("rst_dz",   32'(bus.div_zero), 32'd0);
    chk("rst_busy", 32'(bus.busy),     32'd0);
    reset = 1'b1;

    for (int i = 0; i < 9; i++) begin
      @(negedge clock);
      issue(vecs[i].a, vecs[i].b, vecs[i].sgn);
      wait_done(lat, bok);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_lo", i),  bus.lo,   vecs[i].lo);
      chk($sformatf("v%0d_hi", i),  bus.hi,   vecs[i].hi);
      chk($sformatf("v%0d_dz", i),  32'(bus.div_zero), 32'(vecs[i].dz));
      if (vecs[i].lat > 1) chk($sformatf("v%0d_busy", i), 32'(bok), 32'd1);
      if (vecs[i].dz) begin
        repeat (3) @(negedge clock);
        chk("dz_hold", 32'(bus.div_zero), 32'd1);
        chk("dz_done_pulse", 32'(bus.done), 32'd0);
      end
    end

    // Start during RUN is ignored, and operand changes after acceptance have no effect
    @(negedge clock);
    issue(32'd1000, 32'd10, 1'b0);
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
      if (lat == 10) begin
        bus.a = 32'd77; bus.b = 32'd5; bus.start = 1'b1;
      end
      if (lat == 11) bus.start = 1'b0;
    end while (!bus.done && lat < 100);
    chk("ign_lat", 32'(lat), 32'd34);
    chk("ign_lo",  bus.lo,   32'd100);
    chk("ign_hi",  bus.hi,   32'd0);

    // Back-to-back: start accepted in the DONE cycle
    @(negedge clock);
    issue(32'd50, 32'd7, 1'b0);
    wait_done(lat, bok);
    chk("b2b_lat1", 32'(lat), 32'd34);
    chk("b2b_lo1",  bus.lo,   32'd7);
    chk("b2b_hi1",  bus.hi,   32'd1);
    issue(32'd81, 32'd9, 1'b0);
    wait_done(lat, bok);
    chk("b2b_lat_total", 32'(lat + 34), 32'd68);
    chk("b2b_lo2", bus.lo, 32'd9);
    chk("b2b_hi2", bus.hi, 32'd0);

    // Reset at cycle 12 of a RUN
    @(negedge clock);
    issue(32'd100, 32'd7, 1'b0);
    repeat (12) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("mrst_busy", 32'(bus.busy),     32'd0);
    chk("mrst_done", 32'(bus.done),     32'd0);
    chk("mrst_lo",   bus.lo,            32'd0);
    chk("mrst_hi",   bus.hi,            32'd0);
    chk("mrst_dz",   32'(bus.div_zero), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    issue(32'd200, 32'd9, 1'b0);
    wait_done(lat, bok);
    chk("post_rst_lat", 32'(lat), 32'd34);
    chk("post_rst_lo",  bus.lo,   32'd22);
    chk("post_rst_hi",  bus.hi,   32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
